preadd_mult_add_checker: RTL
============================

PREADD_MULT_ADD_CHECKER -- requirements
Module: preadd_mult_add_checker

Interface
REQ-001 SHALL have parameter AW, default 16, width of ain/din.
REQ-002 SHALL have parameter BW, default 16, width of bin.
REQ-003 SHALL have parameter CW, default 32, width of cin.
REQ-004 SHALL have parameter PW, default 48, width of pout and expected result.
REQ-005 SHALL have parameter LAT, default 3, DUT input-to-pout latency in cycles (1..8).
REQ-006 SHALL have parameter NUM, default 8, number of samples per check run (1..65535).
REQ-007 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port start  input  1  begin a check run.
REQ-010 SHALL have port in_valid  input  1  stimulus presented to DUT this cycle.
REQ-011 SHALL have port subadd  input  1  0 = ain+din, 1 = ain-din.
REQ-012 SHALL have ports ain, din  input  AW signed; bin  input  BW signed; cin  input  CW signed  stimulus mirrored from DUT inputs.
REQ-013 SHALL have port pout  input  PW signed  DUT result.
REQ-014 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port pass  output  1  done and zero mismatches.
REQ-017 SHALL have port err_cnt  output  16  mismatch count, saturating.
REQ-018 SHALL have ports first_err_idx  output  16, first_err_exp  output  PW, first_err_got  output  PW  first mismatch capture.

Function
REQ-019 SHALL compute exp = ((subadd ? ain-din : ain+din) * bin) + cin; pre-add AW+1 bits, product AW+1+BW bits, all operands sign-extended to PW before the final add.
REQ-020 SHALL hold exp and a valid bit in a LAT-deep shift register; stage LAT output is compared with pout on the same cycle.
REQ-021 SHALL compare all PW bits; mismatch when stage-LAT valid and exp != pout.
REQ-022 SHALL implement FSM IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-023 IDLE -> RUN on start; err_cnt, sample index, accepted count cleared on that edge.
REQ-024 In RUN, in_valid accepted into pipeline and accepted count incremented; RUN -> DRAIN on the cycle the NUM-th sample is accepted.
REQ-025 in_valid in IDLE, DRAIN or DONE SHALL be ignored (no pipeline entry).
REQ-026 DRAIN -> DONE when pipeline valid bits are all zero after the final compare.
REQ-027 DONE holds outputs until start, which restarts directly into RUN with counters cleared; start in RUN/DRAIN ignored.
REQ-028 Sample index SHALL count compares (0-based), not accepted inputs.
REQ-029 err_cnt SHALL saturate at 16'hFFFF.
REQ-030 pass SHALL be combinational: done && (err_cnt == 0).

Reset
REQ-031 rst_n low at a rising edge SHALL clear pipeline valid bits, FSM to IDLE, busy=0, done=0, pass=0, err_cnt=0, first_err_* = 0, regardless of state.
REQ-032 Expected-value data registers SHALL need no reset.

Configuration
REQ-033 Macro CHECKER_FIRST_ERR_EN defined: on the first mismatch of a run, first_err_idx/exp/got SHALL latch sample index, exp, pout and hold until next start or reset.
REQ-034 Macro CHECKER_FIRST_ERR_EN undefined: capture registers SHALL not be built; first_err_* tied to 0.

Verification (LAT=3, NUM=4)
REQ-035 start, then 4 valid samples with pout model-correct (e.g. a=3,d=2,b=-4,c=5,subadd=0 -> pout=-15) -> done 3 cycles after last accept drains, pass=1, err_cnt=0.
REQ-036 subadd=1, a=-10,d=10,b=7,c=-1, pout=-141 -> no mismatch; pout forced -140 -> err_cnt=1, first_err_exp=-141, first_err_got=-140 (macro on).
REQ-037 Mismatch on samples 1 and 3 -> err_cnt=2, first_err_idx=1, pass=0.
REQ-038 in_valid pulsed while IDLE, then start + 4 samples -> only the 4 post-start samples compared, err_cnt unaffected by pre-start data.
REQ-039 rst_n low for 1 cycle during DRAIN -> next cycle IDLE, busy=0, done=0, err_cnt=0; no DONE reached.
REQ-040 Extremes a=32767,d=-32768,b=-32768,c=-2147483648,subadd=1 -> exp=-2147450880-2147483648 sign-correct in PW=48, no overflow, pass=1.

Source files
------------

// File: rtl/preadd_mult_add_checker.sv
// preadd_mult_add_checker: compares a pre-add/multiply/add DUT's pout against a LAT-delayed model of its inputs.
// Define CHECKER_FIRST_ERR_EN to build the first-mismatch capture registers.
module preadd_mult_add_checker #(
  parameter int AW  = 16,
  parameter int BW  = 16,
  parameter int CW  = 32,
  parameter int PW  = 48,
  parameter int LAT = 3,
  parameter int NUM = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 subadd,
  input  logic signed [AW-1:0] ain,
  input  logic signed [AW-1:0] din,
  input  logic signed [BW-1:0] bin,
  input  logic signed [CW-1:0] cin,
  input  logic signed [PW-1:0] pout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [15:0]          first_err_idx,
  output logic signed [PW-1:0] first_err_exp,
  output logic signed [PW-1:0] first_err_got
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic signed [AW:0] pre;
  logic signed [AW+BW:0] prod;
  logic signed [PW-1:0] exp_now;
  logic signed [PW-1:0] pe [1:LAT];
  logic [LAT:1] vld;
  logic [15:0] acc, idx;
  logic accept, cmp, mm, clr;
  always_comb begin
    pre     = subadd ? (AW+1)'(ain) - (AW+1)'(din) : (AW+1)'(ain) + (AW+1)'(din);
    prod    = (AW+BW+1)'(pre) * (AW+BW+1)'(bin);
    exp_now = PW'(prod) + PW'(cin);
    accept  = (state == RUN) && in_valid;
    cmp     = vld[LAT];
    mm      = cmp && (pe[LAT] != pout);
    clr     = start && ((state == IDLE) || (state == DONE));
  end
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 16'd0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld     <= '0;
      err_cnt <= '0;
      idx     <= '0;
      acc     <= '0;
    end else begin
      vld[1] <= accept;
      for (int i = 2; i <= LAT; i++) vld[i] <= vld[i-1];
      err_cnt <= clr ? '0 : err_cnt + 16'(mm && (err_cnt != 16'hFFFF));
      idx     <= clr ? '0 : idx + 16'(cmp);
      acc     <= clr ? '0 : acc + 16'(accept);
      state   <= clr ? RUN :
                 (accept && (acc == 16'(NUM-1))) ? DRAIN :
                 ((state == DRAIN) && ~|vld) ? DONE : state;
    end
  end
  // expected-value data carries no reset; only the valid bits qualify it
  always_ff @(posedge clk) begin
    pe[1] <= exp_now;
    for (int i = 2; i <= LAT; i++) pe[i] <= pe[i-1];
  end
`ifdef CHECKER_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (mm && (err_cnt == 16'd0)) begin
      first_err_idx <= idx;
      first_err_exp <= pe[LAT];
      first_err_got <= pout;
    end
  end
`else
  assign first_err_idx = '0;
  assign first_err_exp = '0;
  assign first_err_got = '0;
`endif
endmodule
